// File: rtl/dot_product_seq.sv
// ---------------------------------------------------------------------------
// dot_product_seq
//
// Sequential dot-product engine. A pair of packed integer vectors is accepted
// over a valid/ready handshake, reduced LANES multiply-accumulates per cycle,
// and the sum of products is returned over a second valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds its data stable until
// that edge. valid never depends combinationally on ready.
//
// Parameters
//   ELEM_W   element width in bits
//   N_ELEMS  elements per vector (>= 1)
//   LANES    multiply-accumulates per cycle (1..N_ELEMS)
//   RES_W    result width, derived from the above; not meant to be overridden
//
// Ports
//   clk          clock, all state changes on its rising edge
//   rst          asynchronous active-high reset
//   in_valid     a vector pair is present on vec_a / vec_b
//   in_ready     block can accept a pair (IDLE and not in reset)
//   vec_a        packed vector A, element i at [ELEM_W*i +: ELEM_W]
//   vec_b        packed vector B, same packing
//   out_valid    result holds a completed dot product (registered)
//   out_ready    consumer accepts the result
//   result       sum over i of a[i]*b[i] (registered)
//   dbg_state_o  current FSM state, for checkers and debug
//
// Build option
//   DOT_PRODUCT_SIGNED_EN  when defined, elements are two's-complement and
//                          result is a signed RES_W value; otherwise all
//                          values are unsigned. RES_W is the same either way.
// ---------------------------------------------------------------------------
module dot_product_seq #(
  parameter int ELEM_W  = 4,
  parameter int N_ELEMS = 10,
  parameter int LANES   = 2,
  parameter int RES_W   = 2 * ELEM_W + $clog2(N_ELEMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_ELEMS*ELEM_W-1:0]   vec_a,
  input  logic [N_ELEMS*ELEM_W-1:0]   vec_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RES_W-1:0]            result,
  output logic [1:0]                  dbg_state_o
);

  localparam int VEC_W   = N_ELEMS * ELEM_W;
  localparam int PROD_W  = 2 * ELEM_W;
  localparam int CHUNK_W = LANES * ELEM_W;
  // idx_q + lane offset can reach N_ELEMS + LANES - 1 in the last chunk.
  localparam int IDX_W   = $clog2(N_ELEMS + LANES + 1);

  localparam logic [IDX_W-1:0] N_IDX     = IDX_W'(N_ELEMS);
  localparam logic [IDX_W-1:0] LANES_IDX = IDX_W'(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [VEC_W-1:0]   a_q;
  logic [VEC_W-1:0]   b_q;
  logic [RES_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic               out_valid_q;
  logic [RES_W-1:0]   result_q;

  logic [RES_W-1:0]   chunk_sum;
  logic [RES_W-1:0]   acc_d;
  logic               last_chunk;

  // One lane: product of two elements, extended to the accumulator width.
  function automatic logic [RES_W-1:0] lane_term(input logic [ELEM_W-1:0] a,
                                                 input logic [ELEM_W-1:0] b);
`ifdef DOT_PRODUCT_SIGNED_EN
    logic signed [PROD_W-1:0] p;
    p = $signed({{ELEM_W{a[ELEM_W-1]}}, a}) * $signed({{ELEM_W{b[ELEM_W-1]}}, b});
    // Size cast of a signed value sign-extends into the accumulator width.
    return RES_W'(p);
`else
    logic [PROD_W-1:0] p;
    p = {{ELEM_W{1'b0}}, a} * {{ELEM_W{1'b0}}, b};
    return RES_W'(p);
`endif
  endfunction

  // The operand registers shift down by one chunk per ACCUM cycle, so lane l
  // always reads the low elements. Shifted-in zeros already make lanes past
  // the end of the vector contribute nothing; the index guard states that
  // intent explicitly and keeps it true independent of the shift fill.
  always_comb begin
    chunk_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if ((idx_q + IDX_W'(l)) < N_IDX) begin
        chunk_sum = chunk_sum + lane_term(a_q[ELEM_W*l +: ELEM_W],
                                          b_q[ELEM_W*l +: ELEM_W]);
      end
    end
  end

  assign acc_d      = acc_q + chunk_sum;
  assign last_chunk = (idx_q + LANES_IDX) >= N_IDX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready is high whenever we are here out of reset.
          if (in_valid) begin
            a_q     <= vec_a;
            b_q     <= vec_b;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          a_q   <= a_q >> CHUNK_W;
          b_q   <= b_q >> CHUNK_W;
          acc_q <= acc_d;
          idx_q <= idx_q + LANES_IDX;
          if (last_chunk) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // result_q holds until the consumer takes it; in_valid is ignored.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Reset forces in_ready low even though the state is already IDLE.
  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;

`ifndef SYNTHESIS
  // out_valid is exactly the DONE state.
  a_valid_is_done: assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q == S_DONE));

  // Back-pressure holds the result and the state.
  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_DONE && !out_ready) |=> (state_q == S_DONE && $stable(result_q)));

  // The chunk index never runs past the last partial chunk.
  a_idx_bound: assert property (@(posedge clk) disable iff (rst)
    idx_q < (N_IDX + LANES_IDX));
`endif

endmodule

// File: tb/tb_dot_product_seq.sv
module tb_dot_product_seq;

  localparam int ELEM_W  = 4;
  localparam int N_ELEMS = 10;
  localparam int W       = N_ELEMS * ELEM_W;
  localparam int RES_W   = 2 * ELEM_W + $clog2(N_ELEMS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (LANES=2) ----------------
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     vec_a, vec_b;
  logic [RES_W-1:0] result;
  logic [1:0]       dbg_state;

  dot_product_seq #(.ELEM_W(ELEM_W), .N_ELEMS(N_ELEMS), .LANES(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .vec_a(vec_a), .vec_b(vec_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .dbg_state_o(dbg_state)
  );

  // ---------------- DUT (LANES=3, partial last chunk) ----------------
  logic             in_valid3, in_ready3, out_valid3, out_ready3;
  logic [W-1:0]     vec_a3, vec_b3;
  logic [RES_W-1:0] result3;
  logic [1:0]       dbg_state3;

  dot_product_seq #(.ELEM_W(ELEM_W), .N_ELEMS(N_ELEMS), .LANES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .vec_a(vec_a3), .vec_b(vec_b3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .result(result3), .dbg_state_o(dbg_state3)
  );

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [RES_W-1:0] exp3_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int accept_cyc  = 0;
  int accept_cyc3 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain sum of element products, signed or unsigned.
  function automatic logic [RES_W-1:0] dot_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    logic [ELEM_W-1:0] ea, eb;
    s = 0;
    for (int i = 0; i < N_ELEMS; i++) begin
      ea = a[ELEM_W*i +: ELEM_W];
      eb = b[ELEM_W*i +: ELEM_W];
`ifdef DOT_PRODUCT_SIGNED_EN
      s += int'($signed(ea)) * int'($signed(eb));
`else
      s += int'(ea) * int'(eb);
`endif
    end
    return RES_W'(s);
  endfunction

  function automatic logic [W-1:0] fill(input logic [ELEM_W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < N_ELEMS; i++) r[ELEM_W*i +: ELEM_W] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ramp();
    logic [W-1:0] r;
    for (int i = 0; i < N_ELEMS; i++) r[ELEM_W*i +: ELEM_W] = ELEM_W'(i + 1);
    return r;
  endfunction

  // Output monitors: sampled on the falling edge; a handshake seen here
  // completes on the next rising edge.
  logic ov_prev = 1'b0;
  logic ov3_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        check("latency_l2", cyc - accept_cyc, 5);
        check("in_ready_low_in_done", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
        else check("result_l2", result, exp_q.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid3 && !ov3_prev) check("latency_l3", cyc - accept_cyc3, 4);
      if (out_valid3 && out_ready3) begin
        if (exp3_q.size() == 0) check("spurious_out_valid3", 1, 0);
        else check("result_l3", result3, exp3_q.pop_front());
      end
    end
    ov3_prev = out_valid3;
  end

  // ---------------- driver tasks ----------------
  // Presents a pair, waits (bounded) for acceptance, pushes the expectation.
  // Returns at accept edge + 1 time unit with the accept cycle number.
  task automatic send(input bit sel3, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int acc);
    acc = -1;
    if (sel3) begin in_valid3 = 1'b1; vec_a3 = a; vec_b3 = b; end
    else      begin in_valid  = 1'b1; vec_a  = a; vec_b  = b; end
    for (int n = 0; n < 200 && acc < 0; n++) begin
      @(negedge clk);
      if (sel3 ? in_ready3 : in_ready) begin
        if (sel3) exp3_q.push_back(dot_ref(a, b));
        else      exp_q.push_back(dot_ref(a, b));
        @(posedge clk);
        #1;
        acc = cyc;
        if (sel3) accept_cyc3 = cyc;
        else      accept_cyc  = cyc;
      end
    end
    if (sel3) in_valid3 = 1'b0;
    else      in_valid  = 1'b0;
    if (acc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_out();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_timeout", seen, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp3_q.size() == 0) break;
    end
    check("drain_l2", exp_q.size(), 0);
    check("drain_l3", exp3_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, acc_tmp;
    bit seen;

    rst = 1'b1;
    in_valid = 1'b0;  vec_a = '0;  vec_b = '0;  out_ready = 1'b1;
    in_valid3 = 1'b0; vec_a3 = '0; vec_b3 = '0; out_ready3 = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_state", dbg_state, 0);
    check("rst_in_ready3", in_ready3, 0);
    check("rst_state3", dbg_state3, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    check("in_ready3_after_rst", in_ready3, 1);
    @(posedge clk);
    #1;

    // A all 1, B = 1..10 -> 55, then A=B=all 15 -> 2250 back to back.
    send(1'b0, fill(4'd1), ramp(), acc1);
    send(1'b0, fill(4'd15), fill(4'd15), acc2);
    check("throughput", acc2 - acc1, 7);
    drain();

    // LANES=3: partial last chunk, A=B=all 2 -> 40 after 4 ACCUM cycles.
    send(1'b1, fill(4'd2), fill(4'd2), acc_tmp);
    drain();
    send(1'b1, fill(4'd1), ramp(), acc_tmp);
    drain();

    // A all -1, B all -8: 80 signed, 1200 unsigned.
    send(1'b0, fill(4'hF), fill(4'h8), acc_tmp);
    send(1'b1, fill(4'hF), fill(4'h8), acc_tmp);
    drain();

    // Back-pressure: hold DONE for 8 cycles while in_valid toggles.
    out_ready = 1'b0;
    send(1'b0, fill(4'd1), ramp(), acc_tmp);
    wait_out();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      vec_a = {$urandom, $urandom};
      vec_b = {$urandom, $urandom};
      @(negedge clk);
      check("bp_result", result, 55);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_state", dbg_state, 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, acc_tmp);
    drain();

    // Reset in the 2nd ACCUM cycle discards the computation.
    send(1'b0, fill(4'd9), fill(4'd7), acc_tmp);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_state", dbg_state, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_out_after_rst", seen, 0);
    @(posedge clk);
    #1;
    send(1'b0, fill(4'd3), fill(4'd1), acc_tmp);
    drain();

    // Random pairs on both instances.
    for (int k = 0; k < 6; k++) begin
      send(1'b0, {$urandom_range(255, 0), $urandom}, {$urandom_range(255, 0), $urandom}, acc_tmp);
      send(1'b1, {$urandom_range(255, 0), $urandom}, {$urandom_range(255, 0), $urandom}, acc_tmp);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
